// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and default constants for the push-button
// debouncer (state encoding, default debounce and long-press durations).
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW      = 2'd0,
        S_RISE_CHK = 2'd1,
        S_HIGH     = 2'd2,
        S_FALL_CHK = 2'd3
    } db_state_t;

    // 10 ms and 1 s at a 50 MHz clock.
    localparam int DB_CYCLES_DEFAULT   = 500000;
    localparam int LONG_CYCLES_DEFAULT = 50000000;

endpackage

// File: rtl/debounce_pulse.sv
// debounce_pulse: debounces a synchronized push-button level and emits
// clean single-cycle press / release / long-press events plus a press count.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset, clears all state/outputs
//   din         synchronized raw button level (metastability-free)
//   level       debounced level, registered
//   press       one-cycle pulse on an accepted 0->1 transition
//   release_p   one-cycle pulse on an accepted 1->0 transition
//   long_press  one-cycle pulse after LONG_CYCLES in the accepted-high state
//   press_count accepted presses, wrapping modulo 2^COUNT_W
module debounce_pulse
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DB_CYCLES_DEFAULT,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEFAULT,
    parameter int COUNT_W         = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din,
    output logic               level,
    output logic               press,
    output logic               release_p,
    output logic               long_press,
    output logic [COUNT_W-1:0] press_count
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYCLES - 1);

    db_state_t           state, state_n;
    logic [DB_W-1:0]     db_cnt, db_cnt_n;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
    logic                level_n;
    logic                press_n;
    logic                release_n;
    logic                long_n;
    logic [COUNT_W-1:0]  count_n;
    logic                db_done;
    logic [HOLD_W-1:0]   hold_inc;

    assign db_done  = (db_cnt == DB_LAST);
    // Hold counter saturates so long_press can fire only once per press.
    assign hold_inc = (hold_cnt == HOLD_MAX) ? hold_cnt
                                             : hold_cnt + 1'b1;

    always_comb begin
        state_n    = state;
        db_cnt_n   = db_cnt;
        hold_cnt_n = hold_cnt;
        level_n    = level;
        press_n    = 1'b0;
        release_n  = 1'b0;
        long_n     = 1'b0;
        count_n    = press_count;

        unique case (state)
            S_LOW: begin
                if (din) begin
                    state_n  = S_RISE_CHK;
                    db_cnt_n = '0;
                end
            end

            S_RISE_CHK: begin
                if (!din) begin
                    state_n  = S_LOW;
                    db_cnt_n = '0;
                end else if (db_done) begin
                    state_n    = S_HIGH;
                    db_cnt_n   = '0;
                    hold_cnt_n = '0;
                    level_n    = 1'b1;
                    press_n    = 1'b1;
                    count_n    = press_count + 1'b1;
                end else begin
                    db_cnt_n = db_cnt + 1'b1;
                end
            end

            S_HIGH: begin
                // Every cycle spent in S_HIGH counts toward the hold time,
                // including the one that leaves for S_FALL_CHK, so the
                // long-press pulse can coincide with the start of a release.
                hold_cnt_n = hold_inc;
                long_n     = (hold_cnt == HOLD_PRE);
                if (!din) begin
                    state_n  = S_FALL_CHK;
                    db_cnt_n = '0;
                end
            end

            S_FALL_CHK: begin
                // hold_cnt is frozen here; a bounce back to high resumes it.
                if (din) begin
                    state_n  = S_HIGH;
                    db_cnt_n = '0;
                end else if (db_done) begin
                    state_n   = S_LOW;
                    db_cnt_n  = '0;
                    level_n   = 1'b0;
                    release_n = 1'b1;
                end else begin
                    db_cnt_n = db_cnt + 1'b1;
                end
            end

            default: begin
                state_n  = S_LOW;
                db_cnt_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_LOW;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            level       <= 1'b0;
            press       <= 1'b0;
            release_p   <= 1'b0;
            long_press  <= 1'b0;
            press_count <= '0;
        end else begin
            state       <= state_n;
            db_cnt      <= db_cnt_n;
            hold_cnt    <= hold_cnt_n;
            level       <= level_n;
            press       <= press_n;
            release_p   <= release_n;
            long_press  <= long_n;
            press_count <= count_n;
        end
    end

endmodule

// File: tb/tb_debounce_pulse.sv
// tb_debounce_pulse: directed stimulus with a queue-based scoreboard for
// debounce_pulse (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, COUNT_W=4).
module tb_debounce_pulse;

    localparam int DB = 4;
    localparam int LG = 10;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          din;
    logic          level;
    logic          press;
    logic          release_p;
    logic          long_press;
    logic [CW-1:0] press_count;

    debounce_pulse #(
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LG),
        .COUNT_W        (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .level      (level),
        .press      (press),
        .release_p  (release_p),
        .long_press (long_press),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    // Rising-edge number; at the following falling edge it names the edge
    // whose registered outputs are visible.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_PRESS, EV_REL, EV_LONG} ev_kind_t;

    typedef struct {
        ev_kind_t      kind;
        int            edge_n;
        logic          lvl;
        logic [CW-1:0] cnt;
    } ev_t;

    ev_t  exp_q[$];
    int   checks = 0;
    int   passes = 0;
    bit   mon_on = 1'b0;
    logic prev_level = 1'b0;

    task automatic expect_ev(ev_kind_t k, int e, logic l, int c);
        ev_t ev;
        ev.kind   = k;
        ev.edge_n = e;
        ev.lvl    = l;
        ev.cnt    = CW'(c);
        exp_q.push_back(ev);
    endtask

    task automatic check_evt(ev_kind_t k);
        ev_t ev;
        checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_%s: pulse at edge %0d, none required",
                     k.name(), cyc);
        end else begin
            ev = exp_q.pop_front();
            if (ev.kind == k && ev.edge_n == cyc && ev.lvl === level &&
                ev.cnt === press_count) begin
                passes++;
            end else begin
                $display("FAIL event_%s: got %s@%0d level=%0b count=%0d, required %s@%0d level=%0b count=%0d",
                         ev.kind.name(), k.name(), cyc, level, press_count,
                         ev.kind.name(), ev.edge_n, ev.lvl, ev.cnt);
            end
        end
    endtask

    task automatic chk(string nm, int act, int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, required %0d", nm, act, req);
    endtask

    task automatic drive(logic v, int n);
        for (int i = 0; i < n; i++) begin
            din = v;
            @(negedge clk);
        end
    endtask

    // Monitor: every pulse must match the head of the expected queue, and
    // level may only move together with press or release_p.
    always @(negedge clk) begin
        if (reset || !mon_on) begin
            prev_level = 1'b0;
        end else begin
            if (press)      check_evt(EV_PRESS);
            if (release_p)  check_evt(EV_REL);
            if (long_press) check_evt(EV_LONG);
            if (level !== prev_level && !press && !release_p) begin
                checks++;
                $display("FAIL level_change: level=%0b at edge %0d without pulse, required %0b",
                         level, cyc, prev_level);
            end
            prev_level = level;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required stimulus end");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        din   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_level", level, 0);
        chk("reset_press", press, 0);
        chk("reset_release", release_p, 0);
        chk("reset_long", long_press, 0);
        chk("reset_count", press_count, 0);
        reset  = 1'b0;
        mon_on = 1'b1;
        drive(1'b0, 2);

        // Clean press and release.
        expect_ev(EV_PRESS, cyc + 5, 1'b1, 1);
        drive(1'b1, 6);
        chk("press_one_cycle", press, 0);
        expect_ev(EV_REL, cyc + 5, 1'b0, 1);
        drive(1'b0, 6);

        // Asynchronous reset in S_HIGH with hold_cnt=5.
        expect_ev(EV_PRESS, cyc + 5, 1'b1, 2);
        drive(1'b1, 10);
        #2 reset = 1'b1;
        #1;
        chk("midreset_level", level, 0);
        chk("midreset_press", press, 0);
        chk("midreset_release", release_p, 0);
        chk("midreset_long", long_press, 0);
        chk("midreset_count", press_count, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        expect_ev(EV_PRESS, cyc + 5, 1'b1, 1);
        drive(1'b1, 5);
        expect_ev(EV_REL, cyc + 5, 1'b0, 1);
        drive(1'b0, 6);

        // Glitch of 3 cycles is rejected.
        drive(1'b1, 3);
        drive(1'b0, 5);
        chk("glitch_level", level, 0);
        chk("glitch_count", press_count, 1);

        // Release with bounce 0,1,0 then steady 0.
        expect_ev(EV_PRESS, cyc + 5, 1'b1, 2);
        drive(1'b1, 5);
        expect_ev(EV_REL, cyc + 7, 1'b0, 2);
        drive(1'b0, 1);
        drive(1'b1, 1);
        drive(1'b0, 6);

        // Long press: one pulse 10 edges after press, none on further hold.
        expect_ev(EV_PRESS, cyc + 5, 1'b1, 3);
        expect_ev(EV_LONG, cyc + 15, 1'b1, 3);
        drive(1'b1, 25);
        drive(1'b1, 15);
        expect_ev(EV_REL, cyc + 5, 1'b0, 3);
        drive(1'b0, 6);

        // long_press on the edge that enters S_FALL_CHK.
        expect_ev(EV_PRESS, cyc + 5, 1'b1, 4);
        drive(1'b1, 5);
        drive(1'b1, 9);
        expect_ev(EV_LONG, cyc + 1, 1'b1, 4);
        expect_ev(EV_REL, cyc + 5, 1'b0, 4);
        drive(1'b0, 6);

        // Bounce in S_FALL_CHK at hold_cnt=9, then one more high cycle.
        expect_ev(EV_PRESS, cyc + 5, 1'b1, 5);
        drive(1'b1, 5);
        drive(1'b1, 8);
        drive(1'b0, 2);
        expect_ev(EV_LONG, cyc + 2, 1'b1, 5);
        drive(1'b1, 4);
        expect_ev(EV_REL, cyc + 5, 1'b0, 5);
        drive(1'b0, 6);

        // 16 clean presses: count runs 6..15, wraps to 0, ends at 5.
        for (int i = 0; i < 16; i++) begin
            expect_ev(EV_PRESS, cyc + 5, 1'b1, (6 + i) % 16);
            drive(1'b1, 5);
            expect_ev(EV_REL, cyc + 5, 1'b0, (6 + i) % 16);
            drive(1'b0, 5);
        end
        drive(1'b0, 3);
        chk("final_count", press_count, 5);
        chk("final_level", level, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/debounce_pulse.md
# debounce_pulse

Debounces a mechanical push-button level after it has passed through the two-flop synchronizer, and turns it into clean single-cycle events for the PUF challenge/response control logic. Outputs:
- a stable debounced level;
- a one-cycle press pulse and a one-cycle release pulse;
- a one-cycle long-press pulse;
- a wrapping press counter.

It sits directly downstream of the synchronizer, in the same clock domain; its input is assumed metastability-free.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive cycles the new input level must hold before it is accepted (10 ms at 50 MHz); legal range ≥ 2.
- LONG_CYCLES, 50000000, cycles in the accepted-high state before long_press fires (1 s at 50 MHz); legal range ≥ 1.
- COUNT_W, 16, width of press_count.
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- din  input  1  synchronized raw button level, driven by the synchronizer output.
- level  output  1  debounced level, registered.
- press  output  1  one-cycle pulse on an accepted 0→1 transition.
- release_p  output  1  one-cycle pulse on an accepted 1→0 transition.
- long_press  output  1  one-cycle pulse, at most once per accepted press.
- press_count  output  COUNT_W  number of accepted presses, modulo 2^COUNT_W.

## Operation
- FSM states: S_LOW, S_RISE_CHK, S_HIGH, S_FALL_CHK.
- A stability counter, db_cnt, of width $clog2(DEBOUNCE_CYCLES), is used in the CHK states.
- A hold counter, hold_cnt, of width $clog2(LONG_CYCLES+1), is used in S_HIGH.
- S_LOW:
  - din=1 → S_RISE_CHK, db_cnt=0.
  - Otherwise stay.
- S_RISE_CHK:
  - din=0 → S_LOW, db_cnt=0 (glitch rejected, no output activity).
  - din=1 and db_cnt==DEBOUNCE_CYCLES-1 → S_HIGH; level=1, press=1, press_count+1, hold_cnt=0.
  - Otherwise db_cnt+1.
- S_HIGH:
  - din=0 → S_FALL_CHK, db_cnt=0.
  - Otherwise hold_cnt increments, saturating at LONG_CYCLES.
  - long_press=1 on the single cycle where hold_cnt goes from LONG_CYCLES-1 to LONG_CYCLES.
- S_FALL_CHK:
  - din=1 → S_HIGH, db_cnt=0; hold_cnt keeps its value and resumes counting.
  - din=0 and db_cnt==DEBOUNCE_CYCLES-1 → S_LOW; level=0, release_p=1.
  - Otherwise db_cnt+1; hold_cnt frozen.
- press, release_p and long_press are registered pulses, deasserted on every cycle they are not explicitly set.
- press_count wraps from 2^COUNT_W-1 to 0 silently.

## Timing
- Reset values: level=0, press=0, release_p=0, long_press=0, press_count=0, state=S_LOW, db_cnt=0, hold_cnt=0.
- Reset is asynchronous and takes effect mid-operation from any state. No pulse is emitted on reset assertion or release.
- Press latency: if edge E0 is the first edge sampling din=1 in S_LOW, press and level rise after edge E0+DEBOUNCE_CYCLES and press lasts exactly one cycle. Release latency is symmetric.
- Including the 2-cycle synchronizer, the raw-pin-to-press latency is DEBOUNCE_CYCLES+3 edges.
- A glitch shorter than DEBOUNCE_CYCLES cycles produces no output change.
- long_press is asserted LONG_CYCLES edges after press, counted in S_HIGH only.
- long_press never coincides with press.
- long_press may coincide with the cycle of entry into S_FALL_CHK. Priority: the long_press pulse is still emitted on that cycle.
- level changes only on the same edge as press or release_p.

## Structure
- Shared package debounce_pkg:
  - state enum type db_state_t, 2-bit: S_LOW=0, S_RISE_CHK=1, S_HIGH=2, S_FALL_CHK=3;
  - default parameter constants DB_CYCLES_DEFAULT and LONG_CYCLES_DEFAULT.
- No sub-module inside this block. The synchronizer is instantiated by the parent, which feeds din.
- Single always_ff for state, counters and registered outputs; next-state logic in an always_comb.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, LONG_CYCLES=10, COUNT_W=4.
- Reset mid-operation: assert reset while in S_HIGH with hold_cnt=5 → all outputs 0 immediately (asynchronous). After release, a new press needs 4 more stable cycles.
- Clean press: din=1 held from edge E0 → press=1 and level=1 after E4, press low after E5, press_count=1, no release_p.
- Glitch rejection: din=1 for 3 cycles then 0 → level stays 0, no pulses, state returns to S_LOW, press_count=0.
- Release with bounce: from S_HIGH, din toggles 0,1,0 then holds 0 → no release_p until 4 consecutive zeros. release_p lasts one cycle and level=0 on the same edge.
- Long press: din held high for 20 cycles after press → exactly one long_press, 10 edges after press. A second hold without re-press gives no further pulse.
- Counter wrap: 16 clean press/release cycles → press_count goes 15→0. Also inject a bounce in S_FALL_CHK at hold_cnt=9, then hold high 1 more cycle → long_press still fires.
